// File: rtl/pwm_peripheral.sv
// 16-output PWM/static driver fed by the SPI control registers.
// Define PWM_DUTY_SHADOW_EN to latch the duty cycle only at period boundaries.
module pwm_peripheral #(
  parameter int CLK_DIV = 3000,
  parameter int DIV_W   = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic       pwm_period_start
);

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] presc_q, presc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [15:0]      out_q, out_d;
  logic             start_q, start_d;
  logic [15:0]      en_out, en_pwm;
  logic [7:0]       duty_active;
  logic             tick, period_wrap, pwm_level;

`ifdef PWM_DUTY_SHADOW_EN
  // Duty only changes on the period boundary, so a pulse is never cut or stretched.
  logic [7:0] duty_q, duty_d;

  always_comb begin
    duty_d = duty_q;
    if (period_wrap) duty_d = pwm_duty_cycle;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) duty_q <= 8'h00;
    else        duty_q <= duty_d;
  end

  assign duty_active = duty_q;
`else
  assign duty_active = pwm_duty_cycle;
`endif

  always_comb begin
    tick        = (presc_q == DIV_MAX);
    presc_d     = tick ? '0 : presc_q + DIV_W'(1);
    cnt_d       = tick ? cnt_q + 8'd1 : cnt_q;
    period_wrap = tick && (cnt_q == 8'hFF);
    start_d     = period_wrap;
    // 0xFF is special-cased so full duty covers all 256 ticks.
    pwm_level   = (duty_active == 8'hFF) || (cnt_q < duty_active);
    en_out      = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm      = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    out_d       = en_out & (~en_pwm | {16{pwm_level}});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= 8'h00;
      out_q   <= 16'h0000;
      start_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      start_q <= start_d;
    end
  end

  assign uo_out           = out_q[7:0];
  assign uio_out          = out_q[15:8];
  assign pwm_period_start = start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: a period-formula reference model feeds a scoreboard
// checked cycle by cycle, plus duty/edge/reset scenarios on CLK_DIV=4 and CLK_DIV=1.
module tb_pwm_peripheral;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] eo_lo = 8'h00, eo_hi = 8'h00, ep_lo = 8'h00, ep_hi = 8'h00, duty = 8'h00;
  logic [7:0] uo4, uio4, uo1, uio1;
  logic       ps4, ps1;

  int n_chk = 0;
  int n_fail = 0;

  logic        sb_on = 1'b0;
  logic [16:0] sb[$];
  int unsigned n_clk = 0;
  logic [7:0]  m_shadow = 8'h00;

  always #5 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(4), .DIV_W(12)) u_pwm4 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty),
    .uo_out(uo4), .uio_out(uio4), .pwm_period_start(ps4)
  );

  pwm_peripheral #(.CLK_DIV(1), .DIV_W(2)) u_pwm1 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty),
    .uo_out(uo1), .uio_out(uio1), .pwm_period_start(ps1)
  );

  // Reference for the CLK_DIV=4 instance: after n post-reset edges the tick count
  // is (n/4)%256; the pin after edge n reflects the count before that edge.
  always @(posedge clk) begin : model
    logic [7:0]  c, d;
    logic        lvl, ps;
    logic [15:0] o, eo, ep;
    if (!rst_n) begin
      n_clk = 0; m_shadow = 8'h00; o = 16'h0; ps = 1'b0;
    end else begin
      c = 8'((n_clk / 4) % 256);
`ifdef PWM_DUTY_SHADOW_EN
      d = m_shadow;
`else
      d = duty;
`endif
      lvl = (d == 8'hFF) || (c < d);
      eo = {eo_hi, eo_lo};
      ep = {ep_hi, ep_lo};
      for (int i = 0; i < 16; i++) o[i] = eo[i] & (ep[i] ? lvl : 1'b1);
      n_clk++;
      ps = ((n_clk % 1024) == 0);
      if (ps) m_shadow = duty;
    end
    if (sb_on) sb.push_back({o[15:8], o[7:0], ps});
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    eo_lo = 8'h00; eo_hi = 8'h00; ep_lo = 8'h00; ep_hi = 8'h00; duty = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if ({uio4, uo4, ps4} !== 17'h0) begin
      n_fail++; $display("FAIL reset_div4: got %h need 0", {uio4, uo4, ps4});
    end
    n_chk++;
    if ({uio1, uo1, ps1} !== 17'h0) begin
      n_fail++; $display("FAIL reset_div1: got %h need 0", {uio1, uo1, ps1});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_duty50();
    int hi = 0, uio_bad = 0, starts = 0;
    logic [16:0] e;
    do_reset();
    eo_lo = 8'h01; ep_lo = 8'h01; duty = 8'h80; sb_on = 1'b1;
    for (int k = 1; k <= 3072; k++) begin
      @(negedge clk);
      n_chk++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL duty50_sb: empty at %0d", k); end
      else begin
        e = sb.pop_front();
        if ({uio4, uo4, ps4} !== e) begin
          n_fail++; $display("FAIL duty50_sb: cyc %0d got %h need %h", k, {uio4, uo4, ps4}, e);
        end
      end
      if (k > 1024) hi += int'(uo4[0]);
      if (uio4 != 8'h00) uio_bad++;
      starts += int'(ps4);
    end
    sb_on = 1'b0;
    n_chk++;
    if (hi != 1024) begin n_fail++; $display("FAIL duty50_high: got %0d need 1024", hi); end
    n_chk++;
    if (uio_bad != 0) begin n_fail++; $display("FAIL duty50_uio: %0d nonzero cycles need 0", uio_bad); end
    n_chk++;
    if (starts != 3) begin n_fail++; $display("FAIL duty50_starts: got %0d need 3", starts); end
  endtask

  task automatic test_duty_edges();
    logic [16:0] e;
    for (int j = 0; j < 2; j++) begin
      int hi = 0;
      do_reset();
      eo_lo = 8'h01; ep_lo = 8'h01; duty = (j == 1) ? 8'hFF : 8'h00; sb_on = 1'b1;
      for (int k = 1; k <= 3072; k++) begin
        @(negedge clk);
        n_chk++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL edge_sb: empty at %0d", k); end
        else begin
          e = sb.pop_front();
          if ({uio4, uo4, ps4} !== e) begin
            n_fail++; $display("FAIL edge_sb: duty %h cyc %0d got %h need %h", duty, k, {uio4, uo4, ps4}, e);
          end
        end
        if (k > 1024) hi += int'(uo4[0]);
      end
      sb_on = 1'b0;
      n_chk++;
      if (hi != ((j == 1) ? 2048 : 0)) begin
        n_fail++; $display("FAIL edge_high: duty %h got %0d need %0d", duty, hi, (j == 1) ? 2048 : 0);
      end
    end
  endtask

  task automatic test_static();
    logic [7:0]  hi_en[4]  = '{8'hA5, 8'h00, 8'h0F, 8'hF0};
    logic [7:0]  hi_pwm[4] = '{8'h00, 8'hFF, 8'hF0, 8'hF0};
    logic [7:0]  dty[4]    = '{8'h80, 8'h80, 8'h80, 8'h00};
    logic [7:0]  need[4]   = '{8'hA5, 8'h00, 8'h0F, 8'h00};
    logic [16:0] e;
    do_reset();
    sb_on = 1'b1;
    for (int s = 0; s < 4; s++) begin
      eo_hi = hi_en[s]; ep_hi = hi_pwm[s]; duty = dty[s];
      @(negedge clk);
      n_chk++;
      if (uio4 !== need[s]) begin
        n_fail++; $display("FAIL static_%0d: uio_out got %h need %h", s, uio4, need[s]);
      end
      n_chk++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL static_sb: empty at step %0d", s); end
      else begin
        e = sb.pop_front();
        if ({uio4, uo4, ps4} !== e) begin
          n_fail++; $display("FAIL static_sb: step %0d got %h need %h", s, {uio4, uo4, ps4}, e);
        end
      end
    end
    sb_on = 1'b0;
  endtask

  task automatic test_shadow();
    int hi2 = 0, hi3 = 0;
    logic [16:0] e;
    do_reset();
    eo_lo = 8'h01; ep_lo = 8'h01; duty = 8'h40; sb_on = 1'b1;
    for (int k = 1; k <= 3072; k++) begin
      @(negedge clk);
      n_chk++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL shadow_sb: empty at %0d", k); end
      else begin
        e = sb.pop_front();
        if ({uio4, uo4, ps4} !== e) begin
          n_fail++; $display("FAIL shadow_sb: cyc %0d got %h need %h", k, {uio4, uo4, ps4}, e);
        end
      end
      if (k > 1024 && k <= 2048) hi2 += int'(uo4[0]);
      if (k > 2048) hi3 += int'(uo4[0]);
      if (k == 1152) duty = 8'hC0;
    end
    sb_on = 1'b0;
`ifdef PWM_DUTY_SHADOW_EN
    n_chk++;
    if (hi2 != 256) begin n_fail++; $display("FAIL shadow_p2: got %0d need 256", hi2); end
`else
    n_chk++;
    if (hi2 != 768) begin n_fail++; $display("FAIL shadow_p2: got %0d need 768", hi2); end
`endif
    n_chk++;
    if (hi3 != 768) begin n_fail++; $display("FAIL shadow_p3: got %0d need 768", hi3); end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    logic [16:0] e;
    do_reset();
    eo_lo = 8'hFF; ep_lo = 8'h0F; eo_hi = 8'h3C; duty = 8'h80; sb_on = 1'b1;
    for (int k = 1; k <= 320; k++) begin
      @(negedge clk);
      n_chk++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL rstmid_sb: empty at %0d", k); end
      else begin
        e = sb.pop_front();
        if ({uio4, uo4, ps4} !== e) begin
          n_fail++; $display("FAIL rstmid_sb: cyc %0d got %h need %h", k, {uio4, uo4, ps4}, e);
        end
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    void'(sb.pop_front());
    n_chk++;
    if ({uio4, uo4, ps4} !== 17'h0) begin
      n_fail++; $display("FAIL rstmid_out: got %h need 0", {uio4, uo4, ps4});
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 1100 && first < 0; k++) begin
      @(negedge clk);
      n_chk++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL rstmid_sb: empty at %0d", k); end
      else begin
        e = sb.pop_front();
        if ({uio4, uo4, ps4} !== e) begin
          n_fail++; $display("FAIL rstmid_sb: post cyc %0d got %h need %h", k, {uio4, uo4, ps4}, e);
        end
      end
      if (ps4) first = k;
    end
    sb_on = 1'b0;
    sb.delete();
    n_chk++;
    if (first != 1024) begin n_fail++; $display("FAIL rstmid_start: first at %0d need 1024", first); end
  endtask

  task automatic test_div1();
    int first = -1, next = -1, hi = 0;
    do_reset();
    eo_lo = 8'h01; ep_lo = 8'h01; duty = 8'h03;
    for (int k = 1; k <= 300 && first < 0; k++) begin
      @(negedge clk);
      if (ps1) first = k;
    end
    n_chk++;
    if (first != 256) begin n_fail++; $display("FAIL div1_first: got %0d need 256", first); end
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      hi += int'(uo1[0]);
      if (ps1 && next < 0) next = k;
    end
    n_chk++;
    if (hi != 3) begin n_fail++; $display("FAIL div1_high: got %0d need 3", hi); end
    n_chk++;
    if (next != 256) begin n_fail++; $display("FAIL div1_period: got %0d need 256", next); end
  endtask

  initial begin
    test_reset();
    test_duty50();
    test_duty_edges();
    test_static();
    test_shadow();
    test_reset_mid();
    test_div1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
